// File: rtl/micro_op_queue_pkg.sv
// Shared decoder-side types for the micro-op queue: opcodes, payload struct,
// lane-count type and the serialising-opcode helper.
package micro_op_queue_pkg;

  typedef enum logic [3:0] {
    m_nop     = 4'd0,
    m_add     = 4'd1,
    m_sub     = 4'd2,
    m_xor     = 4'd3,
    m_and     = 4'd4,
    m_or      = 4'd5,
    m_load    = 4'd6,
    m_store   = 4'd7,
    m_branch  = 4'd8,
    m_syscall = 4'd9
  } micro_opcode_t;

  typedef struct packed {
    micro_opcode_t opcode;
    logic [4:0]    rd;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [15:0]   imm;
  } micro_op_t;

  // Default lane widths of the queue; the lane-count type covers the wider side.
  localparam int ENQ_W_DEF    = 2;
  localparam int DEQ_W_DEF    = 2;
  localparam int LANE_MAX_DEF = (ENQ_W_DEF > DEQ_W_DEF) ? ENQ_W_DEF : DEQ_W_DEF;

  typedef logic [$clog2(LANE_MAX_DEF + 1)-1:0] lane_cnt_t;

  // Opcodes that must leave the queue on their own.
  function automatic logic is_serializing(micro_opcode_t opc);
    logic ser_s;
    case (opc)
      m_syscall: ser_s = 1'b1;
      default:   ser_s = 1'b0;
    endcase
    return ser_s;
  endfunction

endpackage

// File: rtl/micro_op_queue_chk.sv
// Protocol checker for the micro-op queue handshake inputs and outputs.
module micro_op_queue_chk #(
  parameter int ENQ_W = 2,
  parameter int DEQ_W = 2,
  localparam int EC_W = $clog2(ENQ_W + 1),
  localparam int DC_W = $clog2(DEQ_W + 1)
) (
  input logic             clk,
  input logic             reset_n,
  input logic             flush,
  input logic [EC_W-1:0]  enq_cnt,
  input logic [DC_W-1:0]  deq_take,
  input logic [DEQ_W-1:0] deq_valid
);

  // Decoder never offers more lanes than exist.
  a_enq_cnt_legal: assert property (@(posedge clk) disable iff (!reset_n)
    enq_cnt <= EC_W'(ENQ_W));

  // Issue side never consumes more lanes than are presented (flush overrides).
  a_deq_take_legal: assert property (@(posedge clk) disable iff (!reset_n)
    flush || (int'(deq_take) <= $countones(deq_valid)));

  // Valid lanes always form a contiguous low run.
  a_deq_valid_thermo: assert property (@(posedge clk) disable iff (!reset_n)
    ((deq_valid & (deq_valid + DEQ_W'(1))) == {DEQ_W{1'b0}}));

endmodule

// File: rtl/micro_op_queue_sel.sv
// Dequeue presentation: picks the oldest entries from storage and trims the
// valid run at a serialising op so it leaves the queue alone.
module micro_op_queue_sel
  import micro_op_queue_pkg::*;
#(
  parameter int DEPTH             = 16,
  parameter int DEQ_W             = 2,
  parameter int SERIALIZE_SYSCALL = 1,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic [PTR_W-1:0] head,
  input  logic [CNT_W-1:0] count,
  input  micro_op_t        mem [DEPTH],
  output logic [DEQ_W-1:0] deq_valid,
  output micro_op_t        deq_ops [DEQ_W]
);

  logic [CNT_W-1:0] avail_s;

  // Number of lanes that could be shown: occupancy clamped to lane count.
  always_comb begin
    if (count < CNT_W'(DEQ_W)) begin
      avail_s = count;
    end else begin
      avail_s = CNT_W'(DEQ_W);
    end
  end

  // Walk lanes oldest-first; a syscall at the head goes alone, a later one ends the run.
  always_comb begin
    logic             cut_s;
    logic [PTR_W-1:0] idx_s;
    micro_op_t        op_s;
    cut_s = 1'b0;
    idx_s = {PTR_W{1'b0}};
    op_s  = '0;
    for (int i = 0; i < DEQ_W; i++) begin
      idx_s        = head + PTR_W'(i);
      op_s         = mem[idx_s];
      deq_valid[i] = 1'b0;
      deq_ops[i]   = '0;
      if ((CNT_W'(i) < avail_s) && !cut_s) begin
        if ((SERIALIZE_SYSCALL != 0) && is_serializing(op_s.opcode)) begin
          deq_valid[i] = (i == 0);
          deq_ops[i]   = (i == 0) ? op_s : '0;
          cut_s        = 1'b1;
        end else begin
          deq_valid[i] = 1'b1;
          deq_ops[i]   = op_s;
        end
      end else begin
        cut_s = 1'b1;
      end
    end
  end

endmodule

// File: rtl/micro_op_queue.sv
// Multi-lane circular micro-op queue between decode and register read.
// Owns pointers, occupancy and storage; presentation lives in micro_op_queue_sel.
module micro_op_queue
  import micro_op_queue_pkg::*;
#(
  parameter int DEPTH             = 16,
  parameter int ENQ_W             = 2,
  parameter int DEQ_W             = 2,
  parameter int SERIALIZE_SYSCALL = 1,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int EC_W  = $clog2(ENQ_W + 1),
  localparam int DC_W  = $clog2(DEQ_W + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic [EC_W-1:0]  enq_cnt,
  input  micro_op_t        enq_ops [ENQ_W],
  output logic             enq_ready,
  output logic [DEQ_W-1:0] deq_valid,
  output micro_op_t        deq_ops [DEQ_W],
  input  logic [DC_W-1:0]  deq_take,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  micro_op_t        mem_r [DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [PTR_W-1:0] head_next_s;
  logic [PTR_W-1:0] tail_next_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;
  logic [CNT_W-1:0] enq_acc_s;
  logic             empty_r;
  logic             full_r;
  logic             enq_ready_r;

  // Ops actually accepted: only when a full group fits and no flush is pending.
  always_comb begin
    if (enq_ready_r && !flush) begin
      enq_acc_s = CNT_W'(enq_cnt);
    end else begin
      enq_acc_s = {CNT_W{1'b0}};
    end
  end

  // Next pointers and occupancy; flush discards everything including this cycle's traffic.
  always_comb begin
    if (flush) begin
      head_next_s  = {PTR_W{1'b0}};
      tail_next_s  = {PTR_W{1'b0}};
      count_next_s = {CNT_W{1'b0}};
    end else begin
      head_next_s  = head_r + PTR_W'(deq_take);
      tail_next_s  = tail_r + PTR_W'(enq_acc_s);
      count_next_s = count_r + enq_acc_s - CNT_W'(deq_take);
    end
  end

  // Pointer/occupancy state plus registered status flags derived from next occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_r      <= {PTR_W{1'b0}};
      tail_r      <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      empty_r     <= 1'b1;
      full_r      <= 1'b0;
      enq_ready_r <= 1'b1;
    end else begin
      head_r      <= head_next_s;
      tail_r      <= tail_next_s;
      count_r     <= count_next_s;
      empty_r     <= (count_next_s == {CNT_W{1'b0}});
      full_r      <= (count_next_s == CNT_W'(DEPTH));
      enq_ready_r <= (count_next_s <= CNT_W'(DEPTH - ENQ_W));
    end
  end

  // Storage write: valid lanes land at consecutive slots from tail, wrapping mod DEPTH.
  always_ff @(posedge clk) begin
    for (int j = 0; j < ENQ_W; j++) begin
      if (enq_ready_r && !flush && (EC_W'(j) < enq_cnt)) begin
        mem_r[tail_r + PTR_W'(j)] <= enq_ops[j];
      end
    end
  end

  assign count     = count_r;
  assign empty     = empty_r;
  assign full      = full_r;
  assign enq_ready = enq_ready_r;

  micro_op_queue_sel #(
    .DEPTH             (DEPTH),
    .DEQ_W             (DEQ_W),
    .SERIALIZE_SYSCALL (SERIALIZE_SYSCALL)
  ) u_sel (
    .head      (head_r),
    .count     (count_r),
    .mem       (mem_r),
    .deq_valid (deq_valid),
    .deq_ops   (deq_ops)
  );

  micro_op_queue_chk #(
    .ENQ_W (ENQ_W),
    .DEQ_W (DEQ_W)
  ) u_chk (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .enq_cnt   (enq_cnt),
    .deq_take  (deq_take),
    .deq_valid (deq_valid)
  );

endmodule

// File: tb/tb_micro_op_queue.sv
// Self-checking bench for micro_op_queue: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_micro_op_queue;
  import micro_op_queue_pkg::*;

  localparam int DEPTH = 16;
  localparam int ENQ_W = 2;
  localparam int DEQ_W = 2;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             flush = 1'b0;
  logic [1:0]       enq_cnt = 2'd0;
  logic [1:0]       deq_take = 2'd0;
  micro_op_t        enq_ops [ENQ_W];
  logic             enq_ready;
  logic [DEQ_W-1:0] deq_valid;
  micro_op_t        deq_ops [DEQ_W];
  logic [4:0]       count;
  logic             empty;
  logic             full;

  int        checks = 0;
  int        failures = 0;
  micro_op_t model_q[$];
  bit        cmp_en = 1'b0;
  int        seq_id = 0;
  micro_op_t first_op;
  micro_op_t second_op;
  bit        fill_mode = 1'b0;

  micro_op_queue #(
    .DEPTH(DEPTH), .ENQ_W(ENQ_W), .DEQ_W(DEQ_W), .SERIALIZE_SYSCALL(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .enq_cnt(enq_cnt),
    .enq_ops(enq_ops), .enq_ready(enq_ready), .deq_valid(deq_valid),
    .deq_ops(deq_ops), .deq_take(deq_take), .count(count),
    .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  function automatic micro_op_t mk_op(micro_opcode_t opc);
    micro_op_t o;
    o.opcode = opc;
    o.rd     = 5'($urandom);
    o.rs1    = 5'($urandom);
    o.rs2    = 5'($urandom);
    o.imm    = 16'(seq_id);
    seq_id++;
    return o;
  endfunction

  function automatic micro_opcode_t rand_opc();
    if ($urandom_range(0, 4) == 0) return m_syscall;
    return micro_opcode_t'($urandom_range(1, 8));
  endfunction

  // Lanes that may leave this cycle: up to DEQ_W oldest, a head syscall alone,
  // otherwise stopping before the first syscall behind the head.
  function automatic int exp_nvalid();
    int avail;
    avail = (model_q.size() < DEQ_W) ? model_q.size() : DEQ_W;
    if (avail == 0) return 0;
    if (model_q[0].opcode == m_syscall) return 1;
    for (int i = 1; i < avail; i++) begin
      if (model_q[i].opcode == m_syscall) return i;
    end
    return avail;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    int n;
    logic [DEQ_W-1:0] ev;
    micro_op_t eo;
    n = exp_nvalid();
    chk("count", 64'(count), 64'(model_q.size()));
    chk("empty", 64'(empty), 64'(model_q.size() == 0));
    chk("full", 64'(full), 64'(model_q.size() == DEPTH));
    chk("enq_ready", 64'(enq_ready), 64'(model_q.size() <= DEPTH - ENQ_W));
    for (int i = 0; i < DEQ_W; i++) begin
      ev[i] = (i < n);
      eo = (i < n) ? model_q[i] : '0;
      chk("deq_ops", 64'(deq_ops[i]), 64'(eo));
    end
    chk("deq_valid", 64'(deq_valid), 64'(ev));
  endtask

  // Outputs depend only on registered state, so the falling edge is a stable sample point.
  always @(negedge clk) begin
    if (cmp_en) compare_all();
  end

  task automatic model_apply(bit f, int ec, int take);
    int acc;
    if (!reset_n || f) begin
      model_q.delete();
    end else begin
      acc = (model_q.size() <= DEPTH - ENQ_W) ? ec : 0;
      for (int i = 0; i < take; i++) void'(model_q.pop_front());
      for (int i = 0; i < acc; i++) model_q.push_back(enq_ops[i]);
    end
  endtask

  task automatic step(bit f, int ec, int take, micro_opcode_t o0, micro_opcode_t o1);
    flush      = f;
    enq_cnt    = 2'(ec);
    deq_take   = 2'(take);
    enq_ops[0] = mk_op(o0);
    enq_ops[1] = mk_op(o1);
    @(posedge clk);
    model_apply(f, ec, take);
    #1;
  endtask

  initial begin
    enq_ops[0] = '0;
    enq_ops[1] = '0;
    #1 reset_n = 1'b0;
    #1 cmp_en = 1'b1;
    step(1'b0, 0, 0, m_nop, m_nop);
    step(1'b0, 0, 0, m_nop, m_nop);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_ready", 64'(enq_ready), 64'd1);
    chk("rst_valid", 64'(deq_valid), 64'd0);
    reset_n = 1'b1;
    step(1'b0, 0, 0, m_nop, m_nop);

    // Fill with pairs; enq_ready must drop once count exceeds DEPTH-ENQ_W.
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 2, 0, m_add, m_sub);
      if (k == 1) begin
        first_op  = enq_ops[0];
        second_op = enq_ops[1];
      end
      chk("t1_ready", 64'(enq_ready), 64'(k < 8));
    end
    chk("t1_count", 64'(count), 64'd16);
    chk("t1_full", 64'(full), 64'd1);
    chk("t1_lane0", 64'(deq_ops[0]), 64'(first_op));
    chk("t1_lane1", 64'(deq_ops[1]), 64'(second_op));
    step(1'b0, 2, 0, m_add, m_add);
    chk("t1_refused", 64'(count), 64'd16);

    // Simultaneous enqueue/dequeue at the ready boundary, then wrap the pointers.
    step(1'b0, 0, 2, m_add, m_add);
    chk("t2_c14", 64'(count), 64'd14);
    step(1'b0, 2, 2, m_or, m_and);
    chk("t2_both", 64'(count), 64'd14);
    for (int k = 0; k < 12; k++) step(1'b0, 2, 2, m_or, m_and);
    for (int k = 0; k < 20 && model_q.size() > 0; k++) step(1'b0, 0, exp_nvalid(), m_nop, m_nop);
    chk("t2_drained", 64'(count), 64'd0);

    // Syscall serialisation.
    step(1'b0, 2, 0, m_add, m_syscall);
    step(1'b0, 2, 0, m_sub, m_xor);
    chk("t3_v1", 64'(deq_valid), 64'b01);
    chk("t3_op1", 64'(deq_ops[0].opcode), 64'(m_add));
    step(1'b0, 0, 1, m_nop, m_nop);
    chk("t3_v2", 64'(deq_valid), 64'b01);
    chk("t3_op2", 64'(deq_ops[0].opcode), 64'(m_syscall));
    step(1'b0, 0, 1, m_nop, m_nop);
    chk("t3_v3", 64'(deq_valid), 64'b11);
    chk("t3_op3a", 64'(deq_ops[0].opcode), 64'(m_sub));
    chk("t3_op3b", 64'(deq_ops[1].opcode), 64'(m_xor));
    step(1'b0, 0, 2, m_nop, m_nop);

    // One-cycle latency into an empty queue.
    chk("t5_pre", 64'(deq_valid), 64'b00);
    step(1'b0, 1, 0, m_add, m_add);
    chk("t5_post", 64'(deq_valid), 64'b01);
    chk("t5_count", 64'(count), 64'd1);

    // Flush overrides same-cycle traffic.
    step(1'b0, 2, 0, m_add, m_or);
    step(1'b0, 2, 0, m_add, m_or);
    step(1'b0, 1, 0, m_add, m_or);
    chk("t4_c6", 64'(count), 64'd6);
    step(1'b1, 2, 2, m_add, m_or);
    chk("t4_count", 64'(count), 64'd0);
    chk("t4_empty", 64'(empty), 64'd1);
    chk("t4_valid", 64'(deq_valid), 64'b00);
    step(1'b0, 1, 0, m_sub, m_sub);
    chk("t4_after", 64'(deq_valid), 64'b01);

    // Random traffic with alternating fill/drain bias and occasional flushes.
    for (int c = 0; c < 3000; c++) begin
      bit f;
      int ec;
      int tk;
      if (c % 250 == 0) fill_mode = bit'($urandom_range(0, 1));
      f  = ($urandom_range(0, 39) == 0);
      ec = fill_mode ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 2));
      tk = int'($urandom_range(0, exp_nvalid()));
      if (fill_mode && tk > 1) tk = 1;
      step(f, ec, tk, rand_opc(), rand_opc());
    end

    // Asynchronous reset mid-cycle with nine entries queued.
    step(1'b1, 0, 0, m_nop, m_nop);
    for (int k = 0; k < 4; k++) step(1'b0, 2, 0, m_add, m_sub);
    step(1'b0, 1, 0, m_xor, m_xor);
    chk("t6_c9", 64'(count), 64'd9);
    #2;
    reset_n = 1'b0;
    model_q.delete();
    #1;
    chk("t6_count", 64'(count), 64'd0);
    chk("t6_empty", 64'(empty), 64'd1);
    chk("t6_valid", 64'(deq_valid), 64'b00);
    chk("t6_ops0", 64'(deq_ops[0]), 64'd0);
    chk("t6_ops1", 64'(deq_ops[1]), 64'd0);
    step(1'b0, 0, 0, m_nop, m_nop);
    step(1'b0, 0, 0, m_nop, m_nop);
    reset_n = 1'b1;
    step(1'b0, 1, 0, m_add, m_add);
    chk("t6_after", 64'(count), 64'd1);
    step(1'b0, 0, 1, m_nop, m_nop);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
